// File: rtl/multicycle_control.sv
// multicycle_control: Moore controller for the shared-memory multicycle ARM datapath.
//
// Decodes the instruction register and steps FETCH -> DECODE -> (MEM*/EXECUTE*/BRANCH) ->
// FETCH, driving the datapath selects and write enables of each step. Holds the NZCV flags
// and gates every architectural write (PC, register file, memory) with the condition field.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   Instr       instruction register contents (stable from the cycle after FETCH)
//   ALUFlags    {N,Z,C,V} produced by the ALU this cycle
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0 = PC, 1 = ALUOut/Result
//   MemWrite    data memory write enable
//   IRWrite     instruction register enable
//   ResultSrc   00 = ALUOut, 01 = Data register, 10 = ALU result
//   ALUSrcA     0 = register A, 1 = PC
//   ALUSrcB     00 = WriteData, 01 = ExtImm, 10 = constant 4
//   ALUControl  00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc      immediate extension select (Instr[27:26])
//   RegSrc      register-file read address selects
//   RegWrite    register file write enable
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       s_bit;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign s_bit = Instr[20];

  // Register addresses and offsets are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  state_e     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       cond_ex_q, cond_ex_d;   // condition result latched at the end of DECODE
  logic       no_write_q;

  // Unconditioned controls produced by the state decoder
  logic       ir_write;
  logic       next_pc;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       alu_op;
  logic       adr_src;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;

  // ALU decoder results
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;

  logic       cond_ex;
  logic       pcs;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      nzcv_q     <= 4'b0000;
      cond_ex_q  <= 1'b0;
      no_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nzcv_q     <= nzcv_d;
      cond_ex_q  <= cond_ex_d;
      // Sampled every cycle so that in ALUWB it holds the value decoded during EXECUTE, and
      // it is 0 again for any later writeback (MEMWB) since the decoder idles outside EXECUTE.
      no_write_q <= no_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-state controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = StFetch;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;

    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = StDecode;
      end
      StDecode: begin
        // PC+8 is computed here for use as R15 by the execute step.
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = funct[5] ? StExecuteI : StExecuteR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        state_d   = funct[0] ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        state_d    = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        mem_w      = 1'b1;
        state_d    = StFetch;
      end
      StExecuteR: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 1'b1;
        state_d   = StAluWb;
      end
      StExecuteI: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = StAluWb;
      end
      StAluWb: begin
        result_src = 2'b00;
        reg_w      = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder: {cmd, S}
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_ctl  = 2'b00;
    flag_w   = 2'b00;
    no_write = 1'b0;
    if (alu_op) begin
      case ({funct[4:1], s_bit})
        5'b01000: alu_ctl = 2'b00;                                    // ADD
        5'b01001: begin alu_ctl = 2'b00; flag_w = 2'b11; end          // ADDS
        5'b00100: alu_ctl = 2'b01;                                    // SUB
        5'b00101: begin alu_ctl = 2'b01; flag_w = 2'b11; end          // SUBS
        5'b00000: alu_ctl = 2'b10;                                    // AND
        5'b00001: begin alu_ctl = 2'b10; flag_w = 2'b10; end          // ANDS
        5'b11000: alu_ctl = 2'b11;                                    // ORR
        5'b11001: begin alu_ctl = 2'b11; flag_w = 2'b10; end          // ORRS
        5'b10101: begin alu_ctl = 2'b01; flag_w = 2'b11; no_write = 1'b1; end  // CMP
        default:  alu_ctl = 2'b00;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Condition check against the stored flags
  // ---------------------------------------------------------------------------
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = nzcv_q;
    case (cond)
      4'h0:    cond_ex = z;                      // EQ
      4'h1:    cond_ex = ~z;                     // NE
      4'h2:    cond_ex = c;                      // CS
      4'h3:    cond_ex = ~c;                     // CC
      4'h4:    cond_ex = n;                      // MI
      4'h5:    cond_ex = ~n;                     // PL
      4'h6:    cond_ex = v;                      // VS
      4'h7:    cond_ex = ~v;                     // VC
      4'h8:    cond_ex = c & ~z;                 // HI
      4'h9:    cond_ex = ~c | z;                 // LS
      4'hA:    cond_ex = ~(n ^ v);               // GE
      4'hB:    cond_ex = n ^ v;                  // LT
      4'hC:    cond_ex = ~z & ~(n ^ v);          // GT
      4'hD:    cond_ex = z | (n ^ v);            // LE
      default: cond_ex = 1'b1;                   // AL and 1111
    endcase
  end

  // Flags and latched condition
  always_comb begin
    nzcv_d    = nzcv_q;
    cond_ex_d = cond_ex_q;
    if (state_q == StDecode) begin
      cond_ex_d = cond_ex;
    end
    // alu_op is high exactly in the two EXECUTE states.
    if (alu_op && cond_ex) begin
      if (flag_w[1]) nzcv_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) nzcv_d[1:0] = ALUFlags[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pcs = branch | (reg_w & (rd == 4'd15));

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    if (!reset) begin
      PCWrite  = next_pc | (pcs & cond_ex_q);
      MemWrite = mem_w & cond_ex_q;
      IRWrite  = ir_write;
      RegWrite = reg_w & cond_ex_q & ~no_write_q;
    end
  end

  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ALUControl = alu_ctl;
  assign ImmSrc     = op;
  assign RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded random/directed bench for multicycle_control. A per-instruction reference model
// predicts the output vector of every cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (Instr),
    .ALUFlags  (ALUFlags),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .RegWrite  (RegWrite)
  );

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
  //  RegSrc, RegWrite}
  localparam logic [15:0] EnMask  = 16'hB001;
  localparam logic [15:0] AllMask = 16'hFFFF;

  logic [15:0] got;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                ImmSrc, RegSrc, RegWrite};

  typedef struct {
    logic [15:0] v;
    logic [15:0] m;
    int          id;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_instr = 0;
  logic [3:0] nzcv_m = 4'h0;

  // Monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ((got & mon_e.m) !== (mon_e.v & mon_e.m)) begin
        errors++;
        $display("FAIL outputs instr %0d cycle %0d: got %h required %h (mask %h)",
                 mon_e.id, mon_e.cyc, got, mon_e.v, mon_e.m);
      end
    end
  end

  // ARM condition semantics
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic [1:0] rs, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] alu,
                                       input logic regw, input logic [31:0] ins);
    logic [1:0] regsrc;
    regsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
    return {pcw, adr, memw, irw, rs, srca, srcb, alu, ins[27:26], regsrc, regw};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [3:0] fl, input logic rst,
                      input logic [15:0] v, input logic [15:0] m, input int id, input int cyc);
    exp_t e;
    @(posedge clk);
    #1;
    Instr    = ins;
    ALUFlags = fl;
    reset    = rst;
    e.v = v; e.m = m; e.id = id; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Issue one instruction; rst_cyc >= 0 asserts reset during that cycle index and aborts.
  task automatic issue(input logic [31:0] ins, input logic [3:0] xfl, input int rst_cyc);
    logic [15:0] cv[$];
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  cmd;
    logic        s, ok, rd15, is_cmp, wr_nz, wr_cv, aborted;
    logic [1:0]  alu;
    logic [15:0] v;
    logic [3:0]  fl;
    op      = ins[27:26];
    funct   = ins[25:20];
    cmd     = funct[4:1];
    s       = funct[0];
    rd15    = ins[15:12] == 4'd15;
    ok      = cond_ok(ins[31:28], nzcv_m);
    is_cmp  = 1'b0;
    wr_nz   = 1'b0;
    wr_cv   = 1'b0;
    alu     = 2'b00;
    aborted = 1'b0;
    cv.push_back(pack(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0, ins));   // fetch
    cv.push_back(pack(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, ins));   // decode
    case (op)
      2'b01: begin
        cv.push_back(pack(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, ins));
        if (funct[0]) begin
          cv.push_back(pack(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, ins));
          cv.push_back(pack(ok && rd15, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, ok, ins));
        end else begin
          cv.push_back(pack(0, 1, ok, 0, 2'b00, 0, 2'b00, 2'b00, 0, ins));
        end
      end
      2'b00: begin
        if (cmd == 4'b0100) begin alu = 2'b00; wr_nz = s; wr_cv = s; end
        else if (cmd == 4'b0010) begin alu = 2'b01; wr_nz = s; wr_cv = s; end
        else if (cmd == 4'b0000) begin alu = 2'b10; wr_nz = s; end
        else if (cmd == 4'b1100) begin alu = 2'b11; wr_nz = s; end
        else if (cmd == 4'b1010 && s) begin alu = 2'b01; wr_nz = 1; wr_cv = 1; is_cmp = 1; end
        cv.push_back(pack(0, 0, 0, 0, 2'b00, 0, funct[5] ? 2'b01 : 2'b00, alu, 0, ins));
        cv.push_back(pack(ok && rd15, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, ok && !is_cmp, ins));
      end
      2'b10: cv.push_back(pack(ok, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0, ins));
      default: ;
    endcase
    for (int i = 0; i < cv.size(); i++) begin
      fl = (i == 2) ? xfl : 4'($urandom);
      if (i == rst_cyc) begin
        v = cv[i] & ~EnMask;
        step(ins, fl, 1'b1, v, AllMask, n_instr, i);
        aborted = 1'b1;
        break;
      end
      step(ins, fl, 1'b0, cv[i], AllMask, n_instr, i);
    end
    if (aborted) nzcv_m = 4'h0;
    else if (op == 2'b00 && ok) begin
      if (wr_nz) nzcv_m[3:2] = xfl[3:2];
      if (wr_cv) nzcv_m[1:0] = xfl[1:0];
    end
    n_instr++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0]  cond, cmd, rd;
    logic [1:0]  op;
    logic        s;
    int          pick;
    cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
    op   = 2'($urandom);
    pick = $urandom_range(0, 5);
    case (pick)
      0: cmd = 4'b0100;
      1: cmd = 4'b0010;
      2: cmd = 4'b0000;
      3: cmd = 4'b1100;
      4: cmd = 4'b1010;
      default: cmd = 4'($urandom);
    endcase
    s  = 1'($urandom);
    rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
    return {cond, op, 1'($urandom), cmd, s, 4'($urandom), rd, 12'($urandom)};
  endfunction

  initial begin
    int rc;
    // Reset held: only the write enables are defined on the very first cycles.
    step(32'h0, 4'h0, 1'b1, 16'h0, EnMask, -1, 0);
    step(32'h0, 4'h0, 1'b1, 16'h0, EnMask, -1, 1);

    issue(32'hE0821003, 4'h0, -1);      // ADD R1,R2,R3
    issue(32'hE5921004, 4'h0, -1);      // LDR R1,[R2,#4]
    issue(32'hE5821004, 4'h0, -1);      // STR R1,[R2,#4]
    issue(32'hE0521003, 4'b0100, -1);   // SUBS -> 0100
    issue(32'hE1510002, 4'b1000, -1);   // CMP -> 1000, no RegWrite
    issue(32'h0A000002, 4'h0, -1);      // BEQ, Z=0: not taken
    issue(32'hE0521003, 4'b0100, -1);   // SUBS -> Z=1
    issue(32'h0A000002, 4'h0, -1);      // BEQ, Z=1: taken
    issue(32'h1082F003, 4'h0, -1);      // ADDNE R15, Z=1: suppressed
    issue(32'hE1510002, 4'b0000, -1);   // CMP -> 0000
    issue(32'h1082F003, 4'h0, -1);      // ADDNE R15, Z=0: writes PC and reg
    issue(32'hEC000000, 4'h0, -1);      // Op=11
    issue(32'hE0921003, 4'b1111, -1);   // ADDS -> 1111
    issue(32'hE5821004, 4'h0, 3);       // STR, reset during MEMWRITE
    issue(32'h0A000002, 4'h0, -1);      // BEQ must fail with flags cleared
    issue(32'h2A000002, 4'h0, -1);      // BCS must fail
    issue(32'h5A000002, 4'h0, -1);      // BPL must pass

    for (int k = 0; k < 400; k++) begin
      rc = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 4) : -1;
      issue(rand_instr(), 4'($urandom), rc);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
